// File: rtl/gcd_seq_if.sv
// Request/response handshake bundle for the gcd front-end.
// The front-end (gcd_seq) uses the slave view; the requester uses the master view.
interface gcd_seq_if #(
  parameter int GCDw = 32,
  parameter int TAGw = 4,
  parameter int CNTw = 16
) ();

  logic            req_valid;
  logic            req_ready;
  logic [GCDw-1:0] req_a;
  logic [GCDw-1:0] req_b;
  logic [TAGw-1:0] req_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [GCDw-1:0] rsp_gcd;
  logic [TAGw-1:0] rsp_tag;
  logic [CNTw-1:0] rsp_cycles;
  logic            rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_gcd, rsp_tag, rsp_cycles, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_gcd, rsp_tag, rsp_cycles, rsp_err
  );

endinterface

// File: rtl/gcd_seq.sv
// Request/response front-end for the gcd engine.
// Accepts operand pairs, sequences the engine through enable/done, bypasses it
// for zero operands (the engine would never terminate), aborts runaway jobs with
// a watchdog, and returns result, tag, RUN-cycle count and error flag.
module gcd_seq #(
  parameter int GCDw   = 32,
  parameter int TAGw   = 4,
  parameter int CNTw   = 16,
  parameter int MAXCYC = 4096
) (
  input  logic            clk,
  input  logic            reset,
  gcd_seq_if.slave        bus,
  output logic            gcd_reset,
  output logic            gcd_enable,
  output logic [GCDw-1:0] gcd_in1,
  output logic [GCDw-1:0] gcd_in2,
  input  logic            gcd_done,
  input  logic [GCDw-1:0] gcd_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HOLD  = 3'd2,
    S_REL   = 3'd3,
    S_ABORT = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Counter value at the start of the last permitted RUN cycle; leaving RUN
  // from there makes rsp_cycles read exactly MAXCYC on an abort.
  localparam logic [CNTw-1:0] CNT_LIMIT = CNTw'(MAXCYC - 1);
  localparam logic [CNTw-1:0] CNT_SAT   = '1;

  state_t          r_state;
  state_t          w_next;
  logic            w_enable;
  logic            w_rsp_valid;
  logic            w_req_ready;
  logic            w_accept;
  logic            w_zero_op;
  logic            w_first_run;
  logic            w_wdog;

  logic            r_gcd_reset;
  logic [GCDw-1:0] r_a;
  logic [GCDw-1:0] r_b;
  logic [TAGw-1:0] r_tag;
  logic [CNTw-1:0] r_cnt;
  logic [GCDw-1:0] r_rsp_gcd;
  logic            r_rsp_err;

  function automatic logic [CNTw-1:0] sat_inc(input logic [CNTw-1:0] v);
    return (v == CNT_SAT) ? v : v + CNTw'(1);
  endfunction

  // Requests are only taken in IDLE; masking with reset keeps every output
  // except gcd_reset low while reset is held.
  assign w_req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_zero_op   = (bus.req_a == '0) || (bus.req_b == '0);
  // In the first RUN cycle the engine is still loading its operands, so a
  // done level then cannot belong to this job.
  assign w_first_run = (r_cnt == '0);
  assign w_wdog      = (r_cnt == CNT_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake/enable decode.
  always_comb begin
    w_next      = r_state;
    w_enable    = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_zero_op ? S_RESP : S_RUN;
      end
      S_RUN: begin
        w_enable = 1'b1;
        if (w_wdog)                         w_next = S_ABORT;
        else if (!w_first_run && gcd_done)  w_next = S_HOLD;
      end
      S_HOLD: begin
        w_enable = 1'b1;
        w_next   = S_REL;
      end
      S_REL: begin
        w_next = S_RESP;
      end
      S_ABORT: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered engine reset: held during reset, one-cycle pulse in ABORT.
  always_ff @(posedge clk) begin
    r_gcd_reset <= reset || (w_next == S_ABORT);
  end

  // Operand latch, RUN-cycle counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_rsp_gcd <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= bus.req_a;
            r_b   <= bus.req_b;
            r_tag <= bus.req_tag;
            r_cnt <= '0;
            if (w_zero_op) begin
              // gcd(x,0) = x and gcd(0,0) is reported as 0; OR selects the
              // non-zero operand without any arithmetic.
              r_rsp_gcd <= bus.req_a | bus.req_b;
              r_rsp_err <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_cnt <= sat_inc(r_cnt);
        end
        S_HOLD: begin
          r_rsp_gcd <= gcd_result;
          r_rsp_err <= 1'b0;
        end
        S_ABORT: begin
          r_rsp_gcd <= '0;
          r_rsp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_gcd    = r_rsp_gcd;
  assign bus.rsp_tag    = r_tag;
  assign bus.rsp_cycles = r_cnt;
  assign bus.rsp_err    = r_rsp_err;

  assign gcd_reset  = r_gcd_reset;
  assign gcd_enable = w_enable;
  assign gcd_in1    = r_a;
  assign gcd_in2    = r_b;

endmodule

// File: tb/tb_gcd_seq.sv
// Bench for gcd_seq with a behavioural subtractive gcd engine attached.
// Engine: loads P/Q on the first enabled cycle, subtracts once per cycle, raises
// done when P==Q and holds it until enable drops. For such an engine a job with
// s subtractions spends s+3 RUN cycles in the front-end.
module tb_gcd_seq;

  localparam int GCDw   = 32;
  localparam int TAGw   = 4;
  localparam int CNTw   = 16;
  localparam int MAXCYC = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            gcd_reset;
  logic            gcd_enable;
  logic [GCDw-1:0] gcd_in1;
  logic [GCDw-1:0] gcd_in2;
  logic            gcd_done;
  logic [GCDw-1:0] gcd_result;

  int n_checks = 0;
  int n_pass   = 0;

  gcd_seq_if #(.GCDw(GCDw), .TAGw(TAGw), .CNTw(CNTw)) bus ();

  gcd_seq #(.GCDw(GCDw), .TAGw(TAGw), .CNTw(CNTw), .MAXCYC(MAXCYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .gcd_reset  (gcd_reset),
    .gcd_enable (gcd_enable),
    .gcd_in1    (gcd_in1),
    .gcd_in2    (gcd_in2),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result)
  );

  always #5 clk = ~clk;

  bit [1:0]  e_st;
  bit        e_done;
  bit [31:0] e_p, e_q, e_res;

  // Behavioural gcd engine with a level done protocol.
  always @(posedge clk) begin
    if (gcd_reset === 1'b1) begin
      e_st   <= 2'd0;
      e_done <= 1'b0;
    end else begin
      case (e_st)
        2'd0: if (gcd_enable === 1'b1) begin
          e_p  <= gcd_in1;
          e_q  <= gcd_in2;
          e_st <= 2'd1;
        end
        2'd1: begin
          if (e_p == e_q) begin
            e_done <= 1'b1;
            e_res  <= e_p;
            e_st   <= 2'd2;
          end else if (e_p > e_q) e_p <= e_p - e_q;
          else                    e_q <= e_q - e_p;
        end
        default: if (gcd_enable !== 1'b1) begin
          e_done <= 1'b0;
          e_st   <= 2'd0;
        end
      endcase
    end
  end

  assign gcd_done   = e_done;
  assign gcd_result = e_res;

  // Present one request at a negedge and hold it until accepted; returns at the
  // negedge following the accepting edge with req_valid dropped.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    for (int k = 0; k < 100; k++) begin
      if (bus.req_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Step negedge by negedge until rsp_valid, tallying engine-side activity.
  task automatic wait_rsp(output int en_c, output int rst_c, output int both_c,
                          output int waited, output bit ok);
    en_c = 0; rst_c = 0; both_c = 0; waited = 0; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (gcd_enable === 1'b1) en_c++;
      if (gcd_reset === 1'b1) rst_c++;
      if (gcd_enable === 1'b1 && gcd_reset === 1'b1) both_c++;
      waited++;
      @(negedge clk);
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (gcd_reset !== 1'b1) $display("FAIL reset_gcd_reset: got %b want 1", gcd_reset); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (gcd_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", gcd_enable); else n_pass++;
    n_checks++; if (bus.rsp_gcd !== 32'd0) $display("FAIL reset_rsp_gcd: got %0d want 0", bus.rsp_gcd); else n_pass++;
    n_checks++; if (bus.rsp_cycles !== 16'd0 || bus.rsp_err !== 1'b0 || bus.rsp_tag !== 4'd0)
      $display("FAIL reset_rsp_fields: got cyc=%0d err=%b tag=%0d want 0/0/0", bus.rsp_cycles, bus.rsp_err, bus.rsp_tag); else n_pass++;
    n_checks++; if (gcd_in1 !== 32'd0 || gcd_in2 !== 32'd0) $display("FAIL reset_operands: got %0d,%0d want 0,0", gcd_in1, gcd_in2); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_checks++; if (gcd_reset !== 1'b0) $display("FAIL idle_gcd_reset: got %b want 0", gcd_reset); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok, rok; int en_c, rst_c, both_c, waited;
    send_req(32'd12, 32'd18, 4'd3, ok);
    n_checks++; if (!ok) $display("FAIL basic_accept: got timeout want accept"); else n_pass++;
    n_checks++; if (gcd_in1 !== 32'd12 || gcd_in2 !== 32'd18) $display("FAIL basic_operands: got %0d,%0d want 12,18", gcd_in1, gcd_in2); else n_pass++;
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!rok) $display("FAIL basic_rsp: got timeout want rsp_valid"); else n_pass++;
    n_checks++; if (bus.rsp_gcd !== 32'd6) $display("FAIL basic_gcd: got %0d want 6", bus.rsp_gcd); else n_pass++;
    n_checks++; if (bus.rsp_tag !== 4'd3) $display("FAIL basic_tag: got %0d want 3", bus.rsp_tag); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL basic_err: got %b want 0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_cycles !== 16'd5) $display("FAIL basic_cycles: got %0d want 5", bus.rsp_cycles); else n_pass++;
    n_checks++; if (en_c != 6) $display("FAIL basic_enable_cycles: got %0d want 6", en_c); else n_pass++;
    n_checks++; if (waited != 7) $display("FAIL basic_latency: got %0d want 7", waited); else n_pass++;
    n_checks++; if (gcd_enable !== 1'b0) $display("FAIL basic_enable_in_resp: got %b want 0", gcd_enable); else n_pass++;
    release_rsp();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL basic_back_idle: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); else n_pass++;
  endtask

  task automatic test_bypass();
    bit ok, rok; int en_c, rst_c, both_c, waited;
    send_req(32'd0, 32'd7, 4'd5, ok);
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!ok || !rok || waited != 0) $display("FAIL bypass_latency: got waited=%0d ok=%b/%b want 0 with accept", waited, ok, rok); else n_pass++;
    n_checks++; if (bus.rsp_gcd !== 32'd7) $display("FAIL bypass_gcd: got %0d want 7", bus.rsp_gcd); else n_pass++;
    n_checks++; if (bus.rsp_cycles !== 16'd0 || bus.rsp_err !== 1'b0 || bus.rsp_tag !== 4'd5)
      $display("FAIL bypass_fields: got cyc=%0d err=%b tag=%0d want 0/0/5", bus.rsp_cycles, bus.rsp_err, bus.rsp_tag); else n_pass++;
    n_checks++; if (gcd_enable !== 1'b0) $display("FAIL bypass_enable: got %b want 0", gcd_enable); else n_pass++;
    release_rsp();
    send_req(32'd0, 32'd0, 4'd6, ok);
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!rok || waited != 0) $display("FAIL bypass00_latency: got waited=%0d want 0", waited); else n_pass++;
    n_checks++; if (bus.rsp_gcd !== 32'd0 || bus.rsp_err !== 1'b0)
      $display("FAIL bypass00_result: got gcd=%0d err=%b want 0/0", bus.rsp_gcd, bus.rsp_err); else n_pass++;
    n_checks++; if (en_c != 0 || gcd_enable !== 1'b0) $display("FAIL bypass00_enable: got %0d cycles want 0", en_c); else n_pass++;
    release_rsp();
  endtask

  task automatic test_backpressure();
    bit ok, rok; int en_c, rst_c, both_c, waited;
    send_req(32'd35, 32'd21, 4'd9, ok);
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!rok) $display("FAIL bp_rsp: got timeout want rsp_valid"); else n_pass++;
    // A competing request sits on the port for the whole stall.
    bus.req_valid = 1'b1; bus.req_a = 32'd100; bus.req_b = 32'd4; bus.req_tag = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== 32'd7 || bus.rsp_tag !== 4'd9 ||
          bus.rsp_cycles !== 16'd6 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got v=%b gcd=%0d tag=%0d cyc=%0d err=%b rdy=%b want 1/7/9/6/0/0",
                 i, bus.rsp_valid, bus.rsp_gcd, bus.rsp_tag, bus.rsp_cycles, bus.rsp_err, bus.req_ready);
      else n_pass++;
    end
    bus.req_valid = 1'b0;
    release_rsp();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); else n_pass++;
  endtask

  task automatic test_watchdog();
    bit ok, rok; int en_c, rst_c, both_c, waited;
    send_req(32'd1, 32'd1000, 4'd2, ok);
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!rok) $display("FAIL wd_rsp: got timeout want rsp_valid"); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_gcd !== 32'd0)
      $display("FAIL wd_result: got err=%b gcd=%0d want 1/0", bus.rsp_err, bus.rsp_gcd); else n_pass++;
    n_checks++; if (bus.rsp_cycles !== 16'd16) $display("FAIL wd_cycles: got %0d want 16", bus.rsp_cycles); else n_pass++;
    n_checks++; if (rst_c != 1) $display("FAIL wd_reset_pulse: got %0d cycles want 1", rst_c); else n_pass++;
    n_checks++; if (both_c != 0 || en_c != 16) $display("FAIL wd_enable: got en=%0d overlap=%0d want 16/0", en_c, both_c); else n_pass++;
    release_rsp();
    send_req(32'd35, 32'd21, 4'd7, ok);
    wait_rsp(en_c, rst_c, both_c, waited, rok);
    n_checks++; if (!rok || bus.rsp_gcd !== 32'd7 || bus.rsp_err !== 1'b0)
      $display("FAIL wd_recover: got ok=%b gcd=%0d err=%b want 1/7/0", rok, bus.rsp_gcd, bus.rsp_err); else n_pass++;
    release_rsp();
  endtask

  task automatic test_reset_midjob();
    bit ok; int seen;
    send_req(32'd1, 32'd1000, 4'd8, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (gcd_enable !== 1'b1) $display("FAIL mid_running: got enable=%b want 1", gcd_enable); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (gcd_enable !== 1'b0 || bus.rsp_valid !== 1'b0 || gcd_reset !== 1'b1 || bus.req_ready !== 1'b0)
      $display("FAIL mid_reset: got en=%b v=%b grst=%b rdy=%b want 0/0/1/0", gcd_enable, bus.rsp_valid, gcd_reset, bus.req_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (gcd_reset !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL mid_after: got grst=%b rdy=%b want 0/1", gcd_reset, bus.req_ready); else n_pass++;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid === 1'b1 || gcd_enable === 1'b1) seen++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    n_checks++; if (seen != 0) $display("FAIL mid_stale: got %0d active cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] av[3] = '{32'd48, 32'd17, 32'd9};
    logic [31:0] bv[3] = '{32'd36, 32'd5, 32'd0};
    logic [31:0] ev[3] = '{32'd12, 32'd1, 32'd9};
    logic [31:0] got_gcd[3];
    logic [3:0]  got_tag[3];
    int got = 0;
    int njobs = 0;
    int low = 0;
    int min_gap = 1000;
    bit prev_en = 1'b0;
    bit drv_ok = 1'b1;
    bus.rsp_ready = 1'b1;
    fork
      begin
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          bit acc;
          acc = 1'b0;
          bus.req_a = av[i]; bus.req_b = bv[i]; bus.req_tag = 4'(i);
          for (int k = 0; k < 100; k++) begin
            if (bus.req_ready === 1'b1) begin
              @(posedge clk);
              acc = 1'b1;
              break;
            end
            @(negedge clk);
          end
          if (!acc) drv_ok = 1'b0;
          @(negedge clk);
        end
        bus.req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && got < 3; c++) begin
          @(negedge clk);
          if (gcd_enable === 1'b1) begin
            if (!prev_en) begin
              if (njobs > 0 && low < min_gap) min_gap = low;
              njobs++;
            end
            low = 0;
          end else low++;
          prev_en = (gcd_enable === 1'b1);
          if (bus.rsp_valid === 1'b1) begin
            got_gcd[got] = bus.rsp_gcd;
            got_tag[got] = bus.rsp_tag;
            got++;
          end
        end
      end
    join
    bus.rsp_ready = 1'b0;
    n_checks++; if (!drv_ok || got != 3) $display("FAIL b2b_count: got %0d responses want 3", got); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i < got) begin
        n_checks++;
        if (got_gcd[i] !== ev[i] || got_tag[i] !== 4'(i))
          $display("FAIL b2b_rsp_%0d: got gcd=%0d tag=%0d want %0d/%0d", i, got_gcd[i], got_tag[i], ev[i], i);
        else n_pass++;
      end
    end
    n_checks++; if (njobs != 2 || min_gap < 2) $display("FAIL b2b_gap: got jobs=%0d gap=%0d want 2 jobs gap>=2", njobs, min_gap); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_watchdog();
    test_reset_midjob();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
